// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch front end: datapath width, the canonical
// NOP encoding, the instruction-buffer entry type and a sequential-PC helper.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Next sequential PC, wrapping modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t used as the fetch-to-decode buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and entry
//   pop               remove head (ignored when empty)
//   flush             empty the buffer; wins over a same-cycle push
//   head              entry at the read pointer
//   count, empty, full  occupancy status
// ---------------------------------------------------------------------------
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_INC = {{PTR_W{1'b0}}, 1'b1};

    fetch_entry_t   mem_r [DEPTH];
    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    logic           pop_s;
    logic           push_s;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign count = wr_ptr_r - rd_ptr_r;
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign head  = mem_r[rd_ptr_r[PTR_W-1:0]];

    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign pop_s  = pop && !empty;
    assign push_s = push && (!full || pop_s);

    // Read/write pointer update; flush discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{instr: NOP_INSTR, pc: {XLEN{1'b0}}};
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, issues in-order requests to a
// variable-latency instruction memory under a credit limit of DEPTH, buffers
// responses and hands one instruction per cycle to Decode. A redirect from
// Execute reloads the PC, flushes the buffer and drops in-flight responses.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        request channel (addr is the PC register)
//   imem_rsp_valid/data              in-order response channel, no backpressure
//   StallD                           Decode cannot accept this cycle
//   PCSrcE, PCTargetE                taken branch/jump redirect and target
//   InstrValidD, InstrD, PCD, PCPlus4D  instruction presented to Decode
// ---------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            StallD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            InstrValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    localparam int               CNT_W        = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  rsp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [CNT_W-1:0] drop_cnt_nxt_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W:0]   inflight_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             credit_ok_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [XLEN-1:0]  pcd_s;
    fetch_entry_t     head_s;
    fetch_entry_t     push_entry_s;

    // Requests in flight plus buffered entries never exceed DEPTH, so every
    // response has a slot waiting for it.
    assign inflight_s  = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    assign credit_ok_s = !fifo_full_s && (inflight_s < CREDIT_LIMIT);

    // Gated by rst_n so no request is visible while memory is held in reset.
    assign imem_req_valid = rst_n && !PCSrcE && credit_ok_s;
    assign imem_req_addr  = pc_r;
    assign accept_s       = imem_req_valid && imem_req_ready;

    // Responses are discarded in the redirect cycle and while stale ones remain.
    assign push_s       = imem_rsp_valid && !PCSrcE && (drop_cnt_r == CNT_ZERO);
    assign pop_s        = !StallD && !PCSrcE && !fifo_empty_s;
    assign push_entry_s = '{instr: imem_rsp_data, pc: rsp_pc_r};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (PCSrcE),
        .head      (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Next values of the in-flight and stale-response counters.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        drop_cnt_nxt_s    = drop_cnt_r;
        if (accept_s && !imem_rsp_valid) begin
            outstanding_nxt_s = outstanding_r + CNT_ONE;
        end else if (!accept_s && imem_rsp_valid) begin
            outstanding_nxt_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
        // Everything still in flight after the redirect cycle is stale; this
        // already includes any drops pending from an earlier redirect.
        if (PCSrcE) begin
            drop_cnt_nxt_s = imem_rsp_valid ? (outstanding_r - CNT_ONE) : outstanding_r;
        end else if (imem_rsp_valid && (drop_cnt_r != CNT_ZERO)) begin
            drop_cnt_nxt_s = drop_cnt_r - CNT_ONE;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // PC, response-PC and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
        end else begin
            if (PCSrcE) begin
                pc_r     <= PCTargetE;
                rsp_pc_r <= PCTargetE;
            end else begin
                if (accept_s) begin
                    pc_r <= pc_plus4(pc_r);
                end
                if (push_s) begin
                    rsp_pc_r <= pc_plus4(rsp_pc_r);
                end
            end
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

    // When the buffer is empty PCD shows the PC the next instruction will carry.
    assign pcd_s       = fifo_empty_s ? rsp_pc_r : head_s.pc;
    assign InstrValidD = !fifo_empty_s;
    assign InstrD      = fifo_empty_s ? NOP_INSTR : head_s.instr;
    assign PCD         = pcd_s;
    assign PCPlus4D    = pc_plus4(pcd_s);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Bench for fetch_unit: a variable-latency memory model, a scoreboard queue of
// expected deliveries filled by the stimulus, and a monitor that pops and
// compares each instruction Decode accepts.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        InstrValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   delivered = 0;
    int   cyc       = 0;
    int   lat       = 1;
    req_t pend_q[$];
    exp_t exp_q[$];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .StallD         (StallD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .InstrValidD    (InstrValidD),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] data_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: p, instr: data_of(p)});
            p = p + 32'd4;
        end
    endtask

    // Instruction memory: in-order, fixed latency 'lat' cycles, reset with rst_n.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) pend_q.delete();
            else if (imem_req_valid && imem_req_ready)
                pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = data_of(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: compare every instruction Decode takes against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !InstrValidD) chk("idle_nop", InstrD, NOP);
            if (rst_n && InstrValidD && !StallD && !PCSrcE) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL sb_underflow: got PCD %h expected no delivery", PCD);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pcd", PCD, e.pc);
                    chk("sb_instr", InstrD, e.instr);
                    chk("sb_pcplus4", PCPlus4D, e.pc + 32'd4);
                    delivered++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        rst_n = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_req_ready = 1'b1; lat = 1;
        next_cycle;
        at_neg;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_valid", 32'(InstrValidD), 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcplus4", PCPlus4D, 32'h4);

        // Sequential fetch, latency 1.
        next_cycle;
        rst_n = 1'b1;
        expect_stream(32'h0, 64);
        at_neg;
        chk("seq_valid_c0", 32'(imem_req_valid), 32'd1);
        chk("seq_addr_c0", imem_req_addr, 32'h0);
        chk("seq_ivd_c0", 32'(InstrValidD), 32'd0);
        next_cycle; at_neg;
        chk("seq_addr_c1", imem_req_addr, 32'h4);
        chk("seq_ivd_c1", 32'(InstrValidD), 32'd0);
        next_cycle; at_neg;
        chk("seq_ivd_c2", 32'(InstrValidD), 32'd1);
        chk("seq_pcd_c2", PCD, 32'h0);
        repeat (6) next_cycle;

        // Decode stall for 8 cycles: credit limit stops requests.
        StallD = 1'b1;
        for (int k = 0; k < 8; k++) begin
            at_neg;
            chk("stall_req_valid", 32'(imem_req_valid), (k < 2) ? 32'd1 : 32'd0);
            chk("stall_ivd", 32'(InstrValidD), 32'd1);
            chk("stall_pcd_hold", PCD, exp_q[0].pc);
            next_cycle;
        end
        StallD = 1'b0;
        repeat (8) next_cycle;

        // Reset, latency 3, redirect with stale responses in flight.
        rst_n = 1'b0; lat = 3; exp_q.delete();
        next_cycle;
        rst_n = 1'b1;
        expect_stream(32'h0, 64);
        at_neg;
        chk("restart_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_addr", imem_req_addr, 32'h0);
        repeat (4) next_cycle;
        PCSrcE = 1'b1; PCTargetE = 32'h100; StallD = 1'b1;
        expect_stream(32'h100, 64);
        at_neg;
        chk("redir_req_withdrawn", 32'(imem_req_valid), 32'd0);
        next_cycle;
        PCSrcE = 1'b0; StallD = 1'b0;
        at_neg;
        chk("redir_ivd_next", 32'(InstrValidD), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_addr", imem_req_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            next_cycle; at_neg;
            chk("redir_drop_ivd", 32'(InstrValidD), 32'd0);
        end
        next_cycle; at_neg;
        chk("redir_first_ivd", 32'(InstrValidD), 32'd1);
        chk("redir_first_pcd", PCD, 32'h100);
        chk("redir_first_pcplus4", PCPlus4D, 32'h104);
        repeat (6) next_cycle;

        // Memory not ready for 4 cycles at PC 0x20.
        PCSrcE = 1'b1; PCTargetE = 32'h20; lat = 1; imem_req_ready = 1'b0;
        expect_stream(32'h20, 64);
        next_cycle;
        PCSrcE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            at_neg;
            chk("notready_valid", 32'(imem_req_valid), 32'd1);
            chk("notready_addr_hold", imem_req_addr, 32'h20);
            next_cycle;
        end
        imem_req_ready = 1'b1;
        at_neg;
        chk("ready_first_addr", imem_req_addr, 32'h20);
        next_cycle; at_neg;
        chk("ready_second_addr", imem_req_addr, 32'h24);
        repeat (6) next_cycle;

        // Asynchronous reset with a filled buffer.
        StallD = 1'b1;
        repeat (2) next_cycle;
        #2;
        chk("pre_reset_ivd", 32'(InstrValidD), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_ivd", 32'(InstrValidD), 32'd0);
        chk("async_rst_instr", InstrD, NOP);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_pcd", PCD, 32'h0);
        next_cycle;
        rst_n = 1'b1; StallD = 1'b0;
        expect_stream(32'h0, 64);
        at_neg;
        chk("post_rst_addr", imem_req_addr, 32'h0);
        chk("post_rst_valid", 32'(imem_req_valid), 32'd1);
        repeat (6) next_cycle;

        // Back-to-back redirects, last one wins; PC wraps past 2^32.
        PCSrcE = 1'b1; PCTargetE = 32'h200; exp_q.delete();
        next_cycle;
        PCTargetE = 32'hFFFF_FFF8;
        expect_stream(32'hFFFF_FFF8, 64);
        next_cycle;
        PCSrcE = 1'b0;
        delivered = 0;
        at_neg;
        chk("b2b_addr", imem_req_addr, 32'hFFFF_FFF8);
        chk("b2b_ivd", 32'(InstrValidD), 32'd0);
        repeat (12) next_cycle;
        chk("b2b_deliveries", 32'(delivered >= 8), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
